// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester ports plus the shared single-port RAM bus.
// slave is the arbiter side, master is the requester/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              write0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              write1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_enable;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
    input  req0, write0, addr0, wdata0,
    input  req1, write1, addr1, wdata1,
    input  mem_data_out,
    output ack0, rdata0, ack1, rdata1,
    output mem_enable, mem_read_write,
    output mem_address, mem_data_in,
    output busy
  );

  modport master (
    output req0, write0, addr0, wdata0,
    output req1, write1, addr1, wdata1,
    output mem_data_out,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_enable, mem_read_write,
    input  mem_address, mem_data_in,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of two ports onto one RAM,
// IDLE -> ACCESS -> DONE, one access per three cycles.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  logic              last;
  logic              gnt;
  logic              pick;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (bus.req0 && bus.req1):  pick = ~last;
      (!bus.req0 && bus.req1): pick = 1'b1;
      default:                 pick = 1'b0;
    endcase
  end

  always_comb begin
    sel_write = bus.write0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (pick) begin
      sel_write = bus.write1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // Bus outputs only move on the edge into ACCESS, so they are
  // stable for the whole enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last               <= 1'b1;
      gnt                <= 1'b0;
      bus.mem_enable     <= 1'b0;
      bus.mem_read_write <= 1'b1;
      bus.mem_address    <= '0;
      bus.mem_data_in    <= '0;
      bus.ack0           <= 1'b0;
      bus.ack1           <= 1'b0;
      bus.rdata0         <= '0;
      bus.rdata1         <= '0;
      bus.busy           <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt                <= pick;
            last               <= pick;
            bus.mem_address    <= sel_addr;
            bus.mem_data_in    <= sel_wdata;
            bus.mem_read_write <= ~sel_write;
            bus.mem_enable     <= 1'b1;
            bus.busy           <= 1'b1;
            state              <= ACCESS;
          end
        end
        ACCESS: begin
          bus.mem_enable <= 1'b0;
          if (bus.mem_read_write) begin
            if (gnt) bus.rdata1 <= bus.mem_data_out;
            else     bus.rdata0 <= bus.mem_data_out;
          end
          bus.ack0 <= ~gnt;
          bus.ack1 <= gnt;
          state    <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level predictor + scoreboard monitor
// against a behavioural RAM, directed scenarios then random traffic.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    if (a == 5) return 32'h1234_5678;
    return {16'(a), ~16'(a)} ^ 32'h5A5A_0000;
  endfunction

  // Behavioural RAM
  bit [31:0] ram   [65536];
  bit        wflag [65536];

  function automatic logic [31:0] ram_rd(input logic [15:0] a);
    return wflag[a] ? ram[a] : init_val(int'(a));
  endfunction

  always @(posedge clk) begin
    if (bus.mem_enable && !bus.mem_read_write) begin
      ram[bus.mem_address]   <= bus.mem_data_in;
      wflag[bus.mem_address] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    bus.mem_data_out <= (bus.mem_enable && bus.mem_read_write)
                      ? ram_rd(bus.mem_address) : 32'hBAD0_BAD0;
  end

  // Reference model: transactions granted, with their cycle slots
  typedef struct {
    bit          port;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          acc;
    int          ack;
    logic [31:0] exp;
  } txn_t;

  txn_t        q[$];
  int          cyc = 0;
  int          next_free = 0;
  bit          last = 1'b1;
  bit          started = 1'b0;
  bit          p;
  logic [31:0] exp_rd [2];
  logic        exp_rw;
  logic [15:0] exp_ma;
  logic [31:0] exp_md;
  txn_t        t;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      next_free = cyc + 1;
      last      = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      exp_rw    = 1'b1;
      exp_ma    = '0;
      exp_md    = '0;
    end else if (cyc >= next_free && (bus.req0 || bus.req1)) begin
      if (bus.req0 && bus.req1) p = !last;
      else                      p = bus.req1;
      t.port  = p;
      t.wr    = p ? bus.write1 : bus.write0;
      t.addr  = p ? bus.addr1  : bus.addr0;
      t.wdata = p ? bus.wdata1 : bus.wdata0;
      t.acc   = cyc + 1;
      t.ack   = cyc + 2;
      t.exp   = '0;
      q.push_back(t);
      last      = p;
      next_free = cyc + 3;
      exp_rw    = !t.wr;
      exp_ma    = t.addr;
      exp_md    = t.wdata;
    end
    cyc++;
    started = 1'b1;
  end

  // Scoreboard monitor
  logic [31:0] refmem [int];
  bit          ea0, ea1, een, ebusy, popq;

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return refmem.exists(int'(a)) ? refmem[int'(a)]
                                  : init_val(int'(a));
  endfunction

  always @(negedge clk) begin
    if (started) begin
      ea0   = 1'b0;
      ea1   = 1'b0;
      een   = 1'b0;
      popq  = 1'b0;
      ebusy = (q.size() != 0);
      if (q.size() != 0 && q[0].acc == cyc) begin
        een = 1'b1;
        if (q[0].wr) refmem[int'(q[0].addr)] = q[0].wdata;
        else         q[0].exp = ref_rd(q[0].addr);
      end
      if (q.size() != 0 && q[0].ack == cyc) begin
        if (q[0].port) ea1 = 1'b1;
        else           ea0 = 1'b1;
        if (!q[0].wr) exp_rd[q[0].port] = q[0].exp;
        popq = 1'b1;
      end
      chk("ack0", 32'(bus.ack0), 32'(ea0));
      chk("ack1", 32'(bus.ack1), 32'(ea1));
      chk("mem_enable", 32'(bus.mem_enable), 32'(een));
      chk("busy", 32'(bus.busy), 32'(ebusy));
      chk("mem_read_write", 32'(bus.mem_read_write), 32'(exp_rw));
      chk("mem_address", 32'(bus.mem_address), 32'(exp_ma));
      chk("mem_data_in", bus.mem_data_in, exp_md);
      chk("rdata0", bus.rdata0, exp_rd[0]);
      chk("rdata1", bus.rdata1, exp_rd[1]);
      if (popq) void'(q.pop_front());
    end
  end

  // Stimulus
  int order[$];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit prt, input bit r, input bit w,
                       input logic [15:0] a, input logic [31:0] d);
    if (prt) begin
      bus.req1 = r; bus.write1 = w;
      bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.write0 = w;
      bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic run_reqs(input bit u0, input bit u1);
    bit p0 = u0;
    bit p1 = u1;
    bit s0, s1;
    int n = 0;
    while ((p0 || p1) && n < 12) begin
      @(negedge clk);
      s0 = bus.ack0;
      s1 = bus.ack1;
      if (s0 && p0) order.push_back(0);
      if (s1 && p1) order.push_back(1);
      @(posedge clk);
      #1;
      if (s0) begin p0 = 1'b0; bus.req0 = 1'b0; end
      if (s1) begin p1 = 1'b0; bus.req1 = 1'b0; end
      n++;
    end
    chk("ack_timeout", 32'(p0 || p1), 32'd0);
  endtask

  initial begin
    int m;
    int a1;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Write then read on port 1
    drive(1, 1, 1, 16'h0010, 32'hDEAD_BEEF);
    run_reqs(0, 1);
    drive(1, 1, 0, 16'h0010, 32'h0);
    run_reqs(0, 1);
    chk("rd_after_wr", bus.rdata1, 32'hDEAD_BEEF);

    // Simultaneous requests alternate
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    order.delete();
    repeat (2) begin
      drive(0, 1, 0, 16'h0000, 32'h0);
      drive(1, 1, 0, 16'h0001, 32'h0);
      run_reqs(1, 1);
    end
    chk("rr_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("rr_0", 32'(order[0]), 32'd0);
      chk("rr_1", 32'(order[1]), 32'd1);
      chk("rr_2", 32'(order[2]), 32'd0);
      chk("rr_3", 32'(order[3]), 32'd1);
    end

    // Port 0 held for nine cycles
    tick(2);
    m  = 0;
    a1 = 0;
    drive(0, 1, 0, 16'h0003, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (bus.ack0) m |= (1 << i);
      if (bus.ack1) a1++;
      @(posedge clk);
      #1;
    end
    bus.req0 = 1'b0;
    chk("b2b_ack0_cycles", 32'(m), 32'h248);
    chk("b2b_ack1", 32'(a1), 32'd0);
    tick(3);

    // A write leaves RData untouched
    drive(0, 1, 0, 16'h0005, 32'h0);
    run_reqs(1, 0);
    chk("rd5", bus.rdata0, 32'h1234_5678);
    drive(0, 1, 1, 16'h0006, 32'hCAFE_F00D);
    run_reqs(1, 0);
    chk("rd_hold", bus.rdata0, 32'h1234_5678);

    // Reset during ACCESS
    drive(1, 1, 1, 16'h0020, 32'h0BAD_F00D);
    tick(1);
    rst = 1'b1;
    bus.req1 = 1'b0;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_enable", 32'(bus.mem_enable), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    a1 = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ack1) a1++;
      @(negedge clk);
    end
    chk("abort_no_ack", 32'(a1), 32'd0);
    @(posedge clk);
    #1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive(0, $urandom_range(0, 2) != 0, 1'($urandom),
            16'($urandom_range(0, 15)), $urandom);
      drive(1, $urandom_range(0, 2) != 0, 1'($urandom),
            16'($urandom_range(0, 15)), $urandom);
      tick(1);
    end
    rst = 1'b0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    tick(6);
    chk("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
